// File: rtl/prewish_arb_pkg.sv
// Shared constants and the FSM state type for the prewish mask arbiter.
package prewish_arb_pkg;

    localparam int DEFAULT_DATA_W         = 8;
    localparam int DEFAULT_HOLDOFF_BITS   = 8;
    localparam int DEFAULT_HOLDOFF_CYCLES = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        HOLD  = ST_HOLD
    } state_t;

endpackage

// File: rtl/prewish_req_latch.sv
// Per-requester capture: strobe rising-edge detect, mask register and pending bit.
// A new edge in the same cycle as clr wins, so a fresh request is never lost.
module prewish_req_latch
    import prewish_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stb,
    input  logic [DATA_W-1:0] dat,
    input  logic              clr,
    output logic              pending,
    output logic [DATA_W-1:0] data
);

    logic stb_q;
    logic rise;

    assign rise = stb & ~stb_q;

    // Edge history, latest-wins data capture, pending with set-over-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q   <= 1'b0;
            pending <= 1'b0;
            data    <= '0;
        end else begin
            stb_q <= stb;
            if (rise) begin
                data    <= dat;
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prewish_mask_arbiter.sv
// Arbitrates several mask sources onto the single mentor STB/DAT load port.
// Optional macro PREWISH_ARB_FIXED_PRIO_EN: lowest pending index always wins
// instead of round-robin.
module prewish_mask_arbiter
    import prewish_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
    parameter int HOLDOFF_BITS   = DEFAULT_HOLDOFF_BITS
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic [NUM_REQ-1:0]        REQ_STB_I,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DAT_I,
    output logic [NUM_REQ-1:0]        REQ_ACK_O,
    output logic                      STB_O,
    output logic [DATA_W-1:0]         DAT_O,
    output logic [NUM_REQ-1:0]        GNT_O,
    output logic                      BUSY_O
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]        PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [HOLDOFF_BITS-1:0] CNT_LOAD = HOLDOFF_BITS'(HOLDOFF_CYCLES - 1);

    logic [NUM_REQ-1:0]             pending;
    logic [NUM_REQ-1:0]             clr;
    logic [NUM_REQ-1:0][DATA_W-1:0] lat_dat;

    state_t                  state, state_nxt;
    logic [PTR_W-1:0]        ptr, ptr_nxt;
    logic [HOLDOFF_BITS-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0]       dat_nxt;
    logic [NUM_REQ-1:0]      gnt_nxt, ack_nxt;
    logic                    stb_nxt;
    logic                    found;
    logic [PTR_W-1:0]        win;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_req
            prewish_req_latch #(.DATA_W(DATA_W)) u_latch (
                .clk     (CLK_I),
                .rst_n   (RST_I),
                .stb     (REQ_STB_I[g]),
                .dat     (REQ_DAT_I[g*DATA_W +: DATA_W]),
                .clr     (clr[g]),
                .pending (pending[g]),
                .data    (lat_dat[g])
            );
        end
    endgenerate

    // Winner search: first pending index after the pointer (or lowest index).
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
`ifdef PREWISH_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && pending[k]) begin
                found = 1'b1;
                win   = PTR_W'(k);
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && pending[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
`endif
    end

    // Next-state and next-output logic for the IDLE/ISSUE/HOLD sequencer.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        dat_nxt   = DAT_O;
        gnt_nxt   = GNT_O;
        stb_nxt   = 1'b0;
        ack_nxt   = '0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    dat_nxt      = lat_dat[win];
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    clr[win]     = 1'b1;
`ifndef PREWISH_ARB_FIXED_PRIO_EN
                    ptr_nxt      = win;
`endif
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                stb_nxt   = 1'b1;
                ack_nxt   = GNT_O;
                cnt_nxt   = CNT_LOAD;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, holdoff counter and registered outputs.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            cnt       <= '0;
            DAT_O     <= '0;
            GNT_O     <= '0;
            STB_O     <= 1'b0;
            REQ_ACK_O <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            DAT_O     <= dat_nxt;
            GNT_O     <= gnt_nxt;
            STB_O     <= stb_nxt;
            REQ_ACK_O <= ack_nxt;
        end
    end

    assign BUSY_O = (state == ISSUE) || (state == HOLD);

endmodule

// File: doc/prewish_mask_arbiter.md
Name: prewish_mask_arbiter

Overview:
Shares the single prewish_mentor write port (STB/DAT mask load) between several mask sources, such as the debounced DIP-switch loader and the auto pattern generator. Each requester posts an 8-bit blink mask with a strobe. The arbiter latches it, picks a winner round-robin, and issues exactly one single-cycle STB_O/DAT_O load to the mentor. It enforces a minimum holdoff between loads so the blinky never sees back-to-back reloads.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 8, mask width
HOLDOFF_CYCLES, 4, idle cycles enforced after each issued strobe (1..255)
HOLDOFF_BITS, 8, holdoff counter width

Ports:
CLK_I  in  1  system clock
RST_I  in  1  asynchronous, active-low reset
REQ_STB_I  in  NUM_REQ  per-requester load strobe; any length, rising edge = one request
REQ_DAT_I  in  NUM_REQ*DATA_W  per-requester mask; slice i = bits [i*DATA_W +: DATA_W]
REQ_ACK_O  out  NUM_REQ  one-cycle pulse when requester i's mask is issued
STB_O  out  1  single-cycle load strobe to mentor STB_I
DAT_O  out  DATA_W  mask to mentor DAT_I; held stable between issues
GNT_O  out  NUM_REQ  one-hot, last granted requester; held
BUSY_O  out  1  high in ISSUE or HOLD

Behaviour:
- Reset (RST_I low, async): STB_O=0, DAT_O=0, REQ_ACK_O=0, GNT_O=0, BUSY_O=0, all pending bits cleared, captured edge history=0, state=IDLE, holdoff count=0, round-robin pointer=NUM_REQ-1 (requester 0 wins first). Reset mid-ISSUE/HOLD aborts at once; no strobe completes.
- Capture: per requester, register REQ_STB_I.
  - Rising edge (now 1, previous 0) at clock N: REQ_DAT_I slice captured, pending[i] set after edge N.
  - Long strobes produce only one request.
  - New edge while pending: data overwritten (latest wins), pending stays set, one issue only.
- FSM:
  - IDLE: if any pending, choose winner = first pending index after pointer (cyclic); latch its data to DAT_O, set GNT_O, clear pending[winner], set pointer=winner, go ISSUE. Else stay.
  - ISSUE (1 cycle): STB_O=1, REQ_ACK_O[winner]=1, load holdoff count=HOLDOFF_CYCLES-1, go HOLD.
  - HOLD: count down; at 0 go IDLE. Requests keep capturing during HOLD.
- Latency: edge captured at N, winner chosen at N+1, STB_O high for the cycle after edge N+2. Edge-to-strobe = 2 clocks when idle.
- Spacing: consecutive STB_O pulses are separated by exactly HOLDOFF_CYCLES+1 low cycles when back-to-back pending.
- Simultaneous: a capture edge on the winner in the same cycle its pending is cleared wins; pending stays set with new data.
- Simultaneous requests from all sources are issued in round-robin order; none is starved (worst wait = NUM_REQ-1 issues).
- DAT_O changes only on the IDLE->ISSUE edge.

Optional Feature:
PREWISH_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest pending index always wins; pointer unused (held at reset value).
- Undefined: round-robin as above.

Decomposition:
- Package prewish_arb_pkg: state enum (IDLE, ISSUE, HOLD) as 2-bit localparams, default DATA_W, HOLDOFF width constants.
- One natural sub-module, prewish_req_latch, generated per requester. It contains the strobe edge detect, data capture register and pending bit, with a clear input and set-wins-over-clear.

Test Plan:
- Reset release; req0 pulses 1 cycle with 8'hA8 at edge N -> STB_O=1 only in cycle after N+2, DAT_O=A8, REQ_ACK_O=01, GNT_O=01.
- req0 (8'h80) and req1 (8'hCA) edge same cycle, HOLDOFF=4 -> STB_O with 80, then 5 low cycles, then STB_O with CA. Repeat both -> order 80, CA again (round-robin).
- req1 holds strobe high 800 cycles with 8'hFF -> exactly one STB_O and one REQ_ACK_O[1].
- req0 edge with 8'h10, then new edge with 8'hE0 while still pending (during HOLD) -> single issue, DAT_O=E0.
- Assert RST_I low during HOLD with req1 pending -> all outputs 0 immediately; after release no strobe until a new edge.
- With PREWISH_ARB_FIXED_PRIO_EN, req0 and req1 re-request continuously -> req0 granted every slot, req1 never; without macro they alternate.
